spi_frame_scheduler: RTL and testbench

// Sequences one downsampled depth frame out over the peripheral SPI link. On a frame request it

---
 rtl/spi_frame_scheduler.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_scheduler.sv
`default_nettype none
// spi_frame_scheduler: walks a downsampled frame in raster order, fetches each pixel from BRAM and
// issues one SPI transaction per pixel, with a CS-low watchdog that retries once before skipping.
module spi_frame_scheduler #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 360,
  parameter int H_STEP     = 4,
  parameter int V_STEP     = 4,
  parameter int BRAM_LAT   = 2,
  parameter int GAP_CYCLES = 8,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic [7:0]            bram_data_in,
  input  logic                  spi_cs_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [7:0]            data_out,
  output logic                  trigger_out,
  output logic [9:0]            hcount_out,
  output logic [8:0]            vcount_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [7:0]            dropped_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    SEND      = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    GAP       = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [15:0] LAT_LAST = 16'(BRAM_LAT);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // Three WAIT_LOW cycles without an ack put the retrigger four cycles after the first trigger.
  localparam logic [15:0] WD_LAST  = 16'd2;
  localparam logic [9:0]  H_LAST   = 10'(H_MAX - H_STEP);
  localparam logic [8:0]  V_LAST   = 9'(V_MAX - V_STEP);
  localparam logic [9:0]  H_INC    = 10'(H_STEP);
  localparam logic [8:0]  V_INC    = 9'(V_STEP);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic        retry;
  logic        cnt_clr, latch, advance, accept, set_retry, pixel_end;
  logic        last_px;

  assign last_px = (hcount_out == H_LAST) && (vcount_out == V_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    cnt_clr        = 1'b0;
    latch          = 1'b0;
    advance        = 1'b0;
    accept         = 1'b0;
    set_retry      = 1'b0;
    pixel_end      = 1'b0;
    trigger_out    = 1'b0;
    frame_done_out = 1'b0;
    busy_out       = 1'b1;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (frame_start_in) begin
          accept   = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (cnt == LAT_LAST) begin
          latch    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        trigger_out = 1'b1;
        cnt_clr     = 1'b1;
        state_nx    = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!spi_cs_in) begin
          state_nx = WAIT_HIGH;
        end else if (cnt == WD_LAST) begin
          if (retry) begin
            pixel_end = 1'b1;
          end else begin
            set_retry = 1'b1;
            state_nx  = SEND;
          end
        end
      end
      WAIT_HIGH: begin
        if (spi_cs_in) pixel_end = 1'b1;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          advance  = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = FETCH;
        end
      end
      DONE: begin
        busy_out       = 1'b0;
        frame_done_out = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A pixel ends either on CS rising or on the second watchdog timeout.
    if (pixel_end) begin
      cnt_clr = 1'b1;
      if (last_px) begin
        state_nx = DONE;
      end else if (GAP_CYCLES == 0) begin
        advance  = 1'b1;
        state_nx = FETCH;
      end else begin
        state_nx = GAP;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt   <= 16'd0;
      retry <= 1'b0;
    end else begin
      cnt <= cnt_clr ? 16'd0 : cnt + 16'd1;
      if (set_retry)  retry <= 1'b1;
      else if (latch) retry <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bram_addr_out <= '0;
      hcount_out    <= 10'd0;
      vcount_out    <= 9'd0;
      data_out      <= 8'd0;
      dropped_out   <= 8'd0;
    end else begin
      if (accept) begin
        bram_addr_out <= '0;
        hcount_out    <= 10'd0;
        vcount_out    <= 9'd0;
      end else if (advance) begin
        bram_addr_out <= bram_addr_out + ADDR_WIDTH'(1);
        if (hcount_out == H_LAST) begin
          hcount_out <= 10'd0;
          vcount_out <= vcount_out + V_INC;
        end else begin
          hcount_out <= hcount_out + H_INC;
        end
      end
      if (latch) data_out <= bram_data_in;
      if (frame_start_in && (state != IDLE) && (dropped_out != 8'hFF))
        dropped_out <= dropped_out + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_scheduler.sv
`default_nettype none
// Bench for spi_frame_scheduler on a reduced 8x4 pixel grid, with a behavioural BRAM and SPI sender.
module tb_spi_frame_scheduler;
  localparam int H_MAX = 32, V_MAX = 16, H_STEP = 4, V_STEP = 4;
  localparam int BRAM_LAT = 2, GAP_CYCLES = 8, ADDR_WIDTH = 14;
  localparam int HP = H_MAX / H_STEP;
  localparam int NPIX = HP * (V_MAX / V_STEP);

  logic                  clk_in = 1'b0;
  logic                  rst_in, frame_start_in, spi_cs_in;
  logic [7:0]            bram_data_in;
  logic [ADDR_WIDTH-1:0] bram_addr_out;
  logic [7:0]            data_out, dropped_out;
  logic                  trigger_out, busy_out, frame_done_out;
  logic [9:0]            hcount_out;
  logic [8:0]            vcount_out;

  spi_frame_scheduler #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .H_STEP(H_STEP), .V_STEP(V_STEP),
    .BRAM_LAT(BRAM_LAT), .GAP_CYCLES(GAP_CYCLES), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .bram_data_in(bram_data_in), .spi_cs_in(spi_cs_in), .bram_addr_out(bram_addr_out),
    .data_out(data_out), .trigger_out(trigger_out), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .dropped_out(dropped_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM with two cycles of read latency
  logic [7:0] mem [NPIX];
  logic [7:0] rd1, rd2;
  always @(posedge clk_in) begin
    rd1 <= mem[int'(bram_addr_out) % NPIX];
    rd2 <= rd1;
  end
  assign bram_data_in = rd2;

  // SPI sender: logs every trigger, optionally ignores it, else holds CS low for L cycles
  int ign_cfg [NPIX];
  int ign_left [NPIX];
  int force_l = 0;
  int log_addr[$], log_h[$], log_v[$], log_d[$], log_cyc[$], log_l[$];

  initial begin
    int a, l;
    spi_cs_in = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      if (trigger_out === 1'b1) begin
        a = int'(bram_addr_out);
        l = 0;
        if (a < NPIX && ign_left[a] > 0) ign_left[a] = ign_left[a] - 1;
        else l = (force_l > 0) ? force_l : int'($urandom_range(1, 6));
        log_addr.push_back(a);
        log_h.push_back(int'(hcount_out));
        log_v.push_back(int'(vcount_out));
        log_d.push_back(int'(data_out));
        log_cyc.push_back(cyc);
        log_l.push_back(l);
        if (l > 0) begin
          @(posedge clk_in); #1;
          spi_cs_in = 1'b0;
          repeat (l - 1) @(posedge clk_in);
          @(posedge clk_in); #1;
          spi_cs_in = 1'b1;
        end
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_h.delete(); log_v.delete();
    log_d.delete(); log_cyc.delete(); log_l.delete();
  endtask

  // Expected trigger stream: pixel k gets one trigger, or two if the sender ignores the first.
  task automatic check_frame(input string tag);
    int exp_n, j;
    exp_n = 0;
    for (int k = 0; k < NPIX; k++) exp_n += (ign_cfg[k] == 0) ? 1 : 2;
    check({tag, "_trig_count"}, log_addr.size(), exp_n);
    if (log_addr.size() == exp_n) begin
      j = 0;
      for (int k = 0; k < NPIX; k++) begin
        for (int t = 0; t < ((ign_cfg[k] == 0) ? 1 : 2); t++) begin
          check({tag, "_addr"}, log_addr[j], k);
          check({tag, "_hcount"}, log_h[j], (k % HP) * H_STEP);
          check({tag, "_vcount"}, log_v[j], (k / HP) * V_STEP);
          check({tag, "_data"}, log_d[j], int'(mem[k]));
          if (t == 1)
            check({tag, "_retrigger_gap"}, log_cyc[j] - log_cyc[j-1], 4);
          else if (j > 0 && log_l[j-1] > 0)
            check({tag, "_pixel_period"}, log_cyc[j] - log_cyc[j-1],
                  1 + BRAM_LAT + 1 + log_l[j-1] + 1 + GAP_CYCLES);
          j++;
        end
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"}, bram_addr_out, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_trigger"}, trigger_out, 0);
    check({tag, "_hcount"}, hcount_out, 0);
    check({tag, "_vcount"}, vcount_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, frame_done_out, 0);
    check({tag, "_dropped"}, dropped_out, 0);
  endtask

  initial begin
    int t0, done_seen, busy_gaps, n_before;
    rst_in = 1'b1;
    frame_start_in = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      ign_cfg[k] = 0;
      ign_left[k] = 0;
      mem[k] = 8'($urandom);
    end
    repeat (3) tick();
    check_idle_zero("reset");
    rst_in = 1'b0;
    tick();

    // Frame 1: one retried pixel, one skipped pixel, three mid-frame requests, one at DONE
    ign_cfg[5] = 1;
    ign_cfg[12] = 2;
    for (int k = 0; k < NPIX; k++) ign_left[k] = ign_cfg[k];
    clear_logs();
    frame_start_in = 1'b1;
    t0 = cyc;
    tick();
    frame_start_in = 1'b0;
    check("f1_start_busy", busy_out, 1);
    check("f1_start_addr", bram_addr_out, 0);
    check("f1_start_trigger", trigger_out, 0);
    done_seen = 0;
    busy_gaps = 0;
    for (int c = 0; c < 20000; c++) begin
      frame_start_in = (c == 40 || c == 140 || c == 240);
      tick();
      if (frame_done_out === 1'b1) begin
        done_seen = 1;
        break;
      end
      if (busy_out !== 1'b1) busy_gaps++;
    end
    frame_start_in = 1'b0;
    check("f1_done_seen", done_seen, 1);
    check("f1_busy_gaps", busy_gaps, 0);
    check("f1_done_busy", busy_out, 0);
    check("f1_dropped_mid", dropped_out, 3);
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    check("f1_done_single", frame_done_out, 0);
    check("f1_after_busy", busy_out, 0);
    tick();
    check("f1_no_restart", busy_out, 0);
    check("f1_dropped_done", dropped_out, 4);
    check("f1_first_latency", log_cyc.size() > 0 ? log_cyc[0] - t0 : -1, 4);
    check_frame("f1");

    // Frame 2: reset while waiting for CS to rise
    for (int k = 0; k < NPIX; k++) begin
      ign_cfg[k] = 0;
      ign_left[k] = 0;
    end
    force_l = 20;
    clear_logs();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    for (int c = 0; c < 2000 && log_addr.size() < 10; c++) tick();
    check("f2_reached_pixel", log_addr.size() >= 10, 1);
    for (int c = 0; c < 100 && spi_cs_in === 1'b1; c++) tick();
    check("f2_cs_low", spi_cs_in, 0);
    repeat (3) tick();
    n_before = log_addr.size();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    force_l = 0;
    check_idle_zero("f2_rst");
    repeat (30) tick();
    check("f2_no_trigger_after_rst", log_addr.size(), n_before);
    check("f2_idle_busy", busy_out, 0);

    // Frame 3: fresh content, restart from address 0
    for (int k = 0; k < NPIX; k++) mem[k] = 8'($urandom);
    clear_logs();
    frame_start_in = 1'b1;
    t0 = cyc;
    tick();
    frame_start_in = 1'b0;
    check("f3_start_busy", busy_out, 1);
    check("f3_start_addr", bram_addr_out, 0);
    done_seen = 0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (frame_done_out === 1'b1) begin
        done_seen = 1;
        break;
      end
    end
    check("f3_done_seen", done_seen, 1);
    check("f3_done_busy", busy_out, 0);
    check("f3_dropped", dropped_out, 0);
    check("f3_first_latency", log_cyc.size() > 0 ? log_cyc[0] - t0 : -1, 4);
    check_frame("f3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
